// File: rtl/video_fade_pkg.sv
// Shared constants and types for the video fade block: brightness level range,
// pipeline depth and the bundle of timing strobes that travels with each pixel.
package video_fade_pkg;

    localparam int LEVEL_MAX  = 8;
    localparam int LEVEL_W    = 4;
    localparam int PIPE_DEPTH = 2;

    typedef logic [LEVEL_W-1:0] level_t;

    typedef struct packed {
        logic hblank;
        logic vblank;
        logic hs;
        logic vs;
    } timing_t;

    localparam timing_t TIMING_RESET = '{hblank: 1'b1, vblank: 1'b1, hs: 1'b0, vs: 1'b0};

    // Gain numerator over 16: 8 at level 0 (half brightness), 16 at level 8 (unity).
    function automatic logic [4:0] level_gain(input level_t level);
        return 5'(LEVEL_MAX) + 5'(level);
    endfunction

endpackage

// File: rtl/video_fade_channel.sv
// One colour channel of the fade: stage 1 registers c*(8+L), stage 2 registers
// the product divided by 16. Both stages advance only on ce_pix.
module fade_channel
    import video_fade_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               ce_pix,
    input  logic [LEVEL_W-1:0] level,
    input  logic [WIDTH-1:0]   c_in,
    output logic [WIDTH-1:0]   c_out
);

    localparam int PW = WIDTH + 5;

    logic [PW-1:0]    prod_d, prod_q;
    logic [WIDTH-1:0] res_d, res_q;

    always_comb begin
        // NOTE: every always_comb output takes its hold value first, so no path leaves it unassigned and no latch is inferred.
        prod_d = prod_q;
        res_d  = res_q;
        if (ce_pix) begin
            prod_d = PW'(c_in) * PW'(level_gain(level));
            res_d  = WIDTH'(prod_q >> 4);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            prod_q <= '0;
            res_q  <= '0;
        end else begin
            prod_q <= prod_d;
            res_q  <= res_d;
        end
    end

    assign c_out = res_q;

endmodule

// File: rtl/video_fade.sv
// Frame-paced brightness fade between the pause stage and arcade_video: steps the
// level down while dimming is requested and delays the timing strobes to match.
module video_fade
    import video_fade_pkg::*;
#(
    parameter int RW              = 8,
    parameter int GW              = 8,
    parameter int BW              = 8,
    parameter int FRAMES_PER_STEP = 30
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               ce_pix,
    input  logic               dim_video,
    input  logic [RW+GW+BW-1:0] rgb_in,
    input  logic               hblank,
    input  logic               vblank,
    input  logic               hs,
    input  logic               vs,
    output logic [RW+GW+BW-1:0] rgb_out,
    output logic               hblank_out,
    output logic               vblank_out,
    output logic               hs_out,
    output logic               vs_out,
    output logic [3:0]         fade_level,
    output logic               fading
);

    localparam int         TW         = RW + GW + BW;
    localparam logic [7:0] FC_LAST    = 8'(FRAMES_PER_STEP - 1);
    localparam level_t     LEVEL_FULL = level_t'(LEVEL_MAX);

    logic                          vblank_d, vblank_q;
    level_t                        level_d, level_q;
    logic [7:0]                    fc_d, fc_q;
    timing_t [PIPE_DEPTH-1:0]      tim_d, tim_q;
    timing_t                       tim_in;
    logic                          vblank_rise;
    logic [RW-1:0]                 r_out;
    logic [GW-1:0]                 g_out;
    logic [BW-1:0]                 b_out;

    assign tim_in      = '{hblank: hblank, vblank: vblank, hs: hs, vs: vs};
    assign vblank_rise = ce_pix && vblank && !vblank_q;

    always_comb begin
        vblank_d = ce_pix ? vblank : vblank_q;
        level_d  = level_q;
        fc_d     = fc_q;
        tim_d    = tim_q;

        if (ce_pix) begin
            tim_d = {tim_q[PIPE_DEPTH-2:0], tim_in};
        end

        // Dropping the request abandons the partial step at once; brightness
        // itself only jumps back on a frame boundary.
        if (!dim_video) begin
            fc_d = '0;
        end

        if (vblank_rise) begin
            if (!dim_video) begin
                level_d = LEVEL_FULL;
            end else if (level_q != '0) begin
                if (fc_q == FC_LAST) begin
                    level_d = level_q - 1'b1;
                    fc_d    = '0;
                end else begin
                    fc_d = fc_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            vblank_q <= 1'b0;
            level_q  <= LEVEL_FULL;
            fc_q     <= '0;
            tim_q    <= {PIPE_DEPTH{TIMING_RESET}};
        end else begin
            vblank_q <= vblank_d;
            level_q  <= level_d;
            fc_q     <= fc_d;
            tim_q    <= tim_d;
        end
    end

    // Each channel samples level_q in stage 1, so a pixel never mixes two levels.
    fade_channel #(.WIDTH(RW)) u_red (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .ce_pix  (ce_pix),
        .level   (level_q),
        .c_in    (rgb_in[TW-1 -: RW]),
        .c_out   (r_out)
    );

    fade_channel #(.WIDTH(GW)) u_green (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .ce_pix  (ce_pix),
        .level   (level_q),
        .c_in    (rgb_in[GW+BW-1 -: GW]),
        .c_out   (g_out)
    );

    fade_channel #(.WIDTH(BW)) u_blue (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .ce_pix  (ce_pix),
        .level   (level_q),
        .c_in    (rgb_in[BW-1:0]),
        .c_out   (b_out)
    );

    assign rgb_out    = {r_out, g_out, b_out};
    assign hblank_out = tim_q[PIPE_DEPTH-1].hblank;
    assign vblank_out = tim_q[PIPE_DEPTH-1].vblank;
    assign hs_out     = tim_q[PIPE_DEPTH-1].hs;
    assign vs_out     = tim_q[PIPE_DEPTH-1].vs;
    assign fade_level = level_q;
    assign fading     = dim_video && (level_q != LEVEL_FULL) && (level_q != '0);

endmodule
